// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int PC_STEP_DEF = 4;

    // Value the PC write port shows out of reset.
    localparam logic [63:0] RESET_PC = 64'h0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FLUSH,
        HOLD,
        SYNC,
        FAULT
    } state_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of all fetch-unit signals toward the PC register, instruction memory and decode.
// master = fetch unit side, slave = surrounding PC register / memory / decode side.
interface fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // PC register
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_write;
    // Redirect
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    // Instruction memory
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    // Decode
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;
    // Status
    logic              fault;

    modport master (
        input  pc_in, branch_valid, branch_target, mem_ready, mem_rdata, instr_ready,
        output pc_next, pc_write, mem_req, mem_addr, instr_out, instr_valid, fault
    );

    modport slave (
        output pc_in, branch_valid, branch_target, mem_ready, mem_rdata, instr_ready,
        input  pc_next, pc_write, mem_req, mem_addr, instr_out, instr_valid, fault
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads the PC, fetches one word over a req/ready
// handshake, hands it to decode over valid/ready, and writes PC+step or a
// branch target back to the PC register.
// Optional misaligned-fetch trap: define FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input logic      clock_in,
    input logic      signal_reset,
    fetch_if.master  bus
);

    state_t            state;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] pc_next_q;
    logic              pc_write_q;
    logic [DATA_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              misaligned;
    logic              mem_req;
    logic              xfer;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              fault_q;
    // A REQ cycle on a misaligned PC never raises a request.
    assign misaligned = (state == REQ) && (bus.pc_in[1:0] != 2'b00);
    assign bus.fault  = fault_q;
`else
    assign misaligned = 1'b0;
    assign bus.fault  = 1'b0;
`endif

    assign mem_req        = ((state == REQ) && !misaligned) || (state == FLUSH);
    assign xfer           = mem_req && bus.mem_ready;
    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = mem_req ? bus.pc_in : '0;
    assign bus.pc_next    = pc_next_q;
    assign bus.pc_write   = pc_write_q;
    assign bus.instr_out  = instr_q;
    assign bus.instr_valid = instr_valid_q;

    // Fetch state machine with registered PC-write, instruction and fault outputs.
    // NOTE: state and outputs use non-blocking assignments so every branch reads
    // the pre-edge values and the block behaves like the flops it describes.
    always_ff @(posedge clock_in) begin
        if (signal_reset) begin
            state         <= IDLE;
            target_q      <= ADDR_W'(RESET_PC);
            pc_next_q     <= ADDR_W'(RESET_PC);
            pc_write_q    <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            pc_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.branch_valid) begin
                        pc_next_q  <= bus.branch_target;
                        pc_write_q <= 1'b1;
                        state      <= SYNC;
                    end else begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.branch_valid) begin
                        // Nothing outstanding if the data arrived now or no request was raised.
                        if (xfer || misaligned) begin
                            pc_next_q  <= bus.branch_target;
                            pc_write_q <= 1'b1;
                            state      <= SYNC;
                        end else begin
                            target_q <= bus.branch_target;
                            state    <= FLUSH;
                        end
                    end else if (misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        fault_q <= 1'b1;
`endif
                        state   <= FAULT;
                    end else if (xfer) begin
                        instr_q       <= bus.mem_rdata;
                        instr_valid_q <= 1'b1;
                        pc_next_q     <= bus.pc_in + ADDR_W'(PC_STEP);
                        pc_write_q    <= 1'b1;
                        state         <= HOLD;
                    end
                end
                FLUSH: begin
                    if (xfer) begin
                        pc_next_q  <= bus.branch_valid ? bus.branch_target : target_q;
                        pc_write_q <= 1'b1;
                        state      <= SYNC;
                    end else if (bus.branch_valid) begin
                        target_q <= bus.branch_target;
                    end
                end
                HOLD: begin
                    if (bus.branch_valid) begin
                        instr_valid_q <= 1'b0;
                        pc_next_q     <= bus.branch_target;
                        pc_write_q    <= 1'b1;
                        state         <= SYNC;
                    end else if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state         <= REQ;
                    end
                end
                SYNC: begin
                    if (bus.branch_valid) begin
                        pc_next_q  <= bus.branch_target;
                        pc_write_q <= 1'b1;
                    end else begin
                        state <= REQ;
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                FAULT: begin
                    if (bus.branch_valid) begin
                        fault_q    <= 1'b0;
                        pc_next_q  <= bus.branch_target;
                        pc_write_q <= 1'b1;
                        state      <= SYNC;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. A small PC-register model
// loads pc_next on pc_write; pc_set lets a scenario place the PC directly.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic        pc_set = 1'b1;
    logic [31:0] pc_set_val = 32'h0;

    fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    fetch_unit dut (
        .clock_in     (clk),
        .signal_reset (rst),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    // PC register model
    always @(posedge clk) begin
        if (pc_set)            bus.pc_in <= pc_set_val;
        else if (bus.pc_write) bus.pc_in <= bus.pc_next;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_set = 1'b1; pc_set_val = 32'h0;
        step(); step(); #1;
        checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL rst_pc_write got=%0h exp=0", bus.pc_write); end
        checks++; if (bus.pc_next !== 32'h0) begin failures++; $display("FAIL rst_pc_next got=%0h exp=0", bus.pc_next); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid got=%0h exp=0", bus.instr_valid); end
        checks++; if (bus.instr_out !== 32'h0) begin failures++; $display("FAIL rst_instr_out got=%0h exp=0", bus.instr_out); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0h exp=0", bus.fault); end
        rst = 1'b0; pc_set = 1'b0;
    endtask

    // Zero-wait memory and decode: fetch 0, 4, 8 one instruction per two cycles.
    task automatic test_sequential();
        bus.mem_ready = 1'b1; bus.instr_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.mem_rdata = 32'hA000_0000 + i; #1;
            checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL seq_req%0d got=%0h exp=1", i, bus.mem_req); end
            checks++; if (bus.mem_addr !== 32'(4*i)) begin failures++; $display("FAIL seq_addr%0d got=%0h exp=%0h", i, bus.mem_addr, 4*i); end
            checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL seq_nowrite%0d got=%0h exp=0", i, bus.pc_write); end
            step();
            checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%0h exp=1", i, bus.instr_valid); end
            checks++; if (bus.instr_out !== 32'hA000_0000 + i) begin failures++; $display("FAIL seq_instr%0d got=%0h exp=%0h", i, bus.instr_out, 32'hA000_0000 + i); end
            checks++; if (bus.pc_write !== 1'b1) begin failures++; $display("FAIL seq_write%0d got=%0h exp=1", i, bus.pc_write); end
            checks++; if (bus.pc_next !== 32'(4*(i+1))) begin failures++; $display("FAIL seq_pc_next%0d got=%0h exp=%0h", i, bus.pc_next, 4*(i+1)); end
            checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL seq_hold_req%0d got=%0h exp=0", i, bus.mem_req); end
            step();
        end
    endtask

    // Memory not ready for 3 cycles at PC 12.
    task automatic test_mem_stall();
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin bus.mem_ready = 1'b1; bus.mem_rdata = 32'hB000_0000; end
            #1;
            checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL stall_req%0d got=%0h exp=1", k, bus.mem_req); end
            checks++; if (bus.mem_addr !== 32'd12) begin failures++; $display("FAIL stall_addr%0d got=%0h exp=c", k, bus.mem_addr); end
            checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL stall_write%0d got=%0h exp=0", k, bus.pc_write); end
            step();
        end
    endtask

    // Decode not ready for 5 cycles in HOLD.
    task automatic test_decode_stall();
        bus.instr_ready = 1'b0; bus.mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL dstall_valid%0d got=%0h exp=1", k, bus.instr_valid); end
            checks++; if (bus.instr_out !== 32'hB000_0000) begin failures++; $display("FAIL dstall_instr%0d got=%0h exp=b0000000", k, bus.instr_out); end
            checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL dstall_req%0d got=%0h exp=0", k, bus.mem_req); end
            checks++; if (bus.pc_write !== (k == 0)) begin failures++; $display("FAIL dstall_write%0d got=%0h exp=%0h", k, bus.pc_write, (k == 0)); end
            if (k == 0) begin
                checks++; if (bus.pc_next !== 32'd16) begin failures++; $display("FAIL dstall_pc_next got=%0h exp=10", bus.pc_next); end
            end
            step();
        end
        bus.instr_ready = 1'b1;
        step(); #1;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL dstall_drop got=%0h exp=0", bus.instr_valid); end
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL dstall_resume_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'd16) begin failures++; $display("FAIL dstall_resume_addr got=%0h exp=10", bus.mem_addr); end
    endtask

    // Branch during a stalled REQ: flush the response, redirect to 0x100.
    task automatic test_branch_flush();
        bus.mem_ready = 1'b0; bus.branch_valid = 1'b1; bus.branch_target = 32'h100;
        step();
        bus.branch_valid = 1'b0; #1;
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL flush_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'd16) begin failures++; $display("FAIL flush_addr got=%0h exp=10", bus.mem_addr); end
        checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL flush_write got=%0h exp=0", bus.pc_write); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ready = 1'b0; #1;
        checks++; if (bus.pc_write !== 1'b1) begin failures++; $display("FAIL flush_sync_write got=%0h exp=1", bus.pc_write); end
        checks++; if (bus.pc_next !== 32'h100) begin failures++; $display("FAIL flush_sync_pc got=%0h exp=100", bus.pc_next); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%0h exp=0", bus.instr_valid); end
        step(); #1;
        checks++; if (bus.mem_addr !== 32'h100) begin failures++; $display("FAIL flush_next_addr got=%0h exp=100", bus.mem_addr); end
        checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL flush_single_write got=%0h exp=0", bus.pc_write); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hC000_0100;
        step(); #1;
        checks++; if (bus.instr_out !== 32'hC000_0100) begin failures++; $display("FAIL flush_instr got=%0h exp=c0000100", bus.instr_out); end
        checks++; if (bus.pc_next !== 32'h104) begin failures++; $display("FAIL flush_seq_pc got=%0h exp=104", bus.pc_next); end
        // Place the PC at the top of the address space for the wrap scenario.
        pc_set = 1'b1; pc_set_val = 32'hFFFF_FFFC;
        step();
        pc_set = 1'b0;
    endtask

    // PC+4 wraps modulo 2^32 without raising a fault.
    task automatic test_wrap();
        bus.mem_rdata = 32'hC000_FFFC; #1;
        checks++; if (bus.mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%0h exp=fffffffc", bus.mem_addr); end
        step(); #1;
        checks++; if (bus.pc_next !== 32'h0) begin failures++; $display("FAIL wrap_pc_next got=%0h exp=0", bus.pc_next); end
        checks++; if (bus.pc_write !== 1'b1) begin failures++; $display("FAIL wrap_write got=%0h exp=1", bus.pc_write); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL wrap_fault got=%0h exp=0", bus.fault); end
        step(); #1;
        checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr got=%0h exp=0", bus.mem_addr); end
    endtask

    // Branch in HOLD, then branch coinciding with a transfer (beats PC+4).
    task automatic test_branch_priority();
        bus.mem_rdata = 32'hD000_0000;
        step();
        bus.branch_valid = 1'b1; bus.branch_target = 32'h200; #1;
        step();
        bus.branch_valid = 1'b0; #1;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL bhold_valid got=%0h exp=0", bus.instr_valid); end
        checks++; if (bus.pc_next !== 32'h200) begin failures++; $display("FAIL bhold_pc got=%0h exp=200", bus.pc_next); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL bhold_sync_req got=%0h exp=0", bus.mem_req); end
        step(); #1;
        checks++; if (bus.mem_addr !== 32'h200) begin failures++; $display("FAIL bhold_addr got=%0h exp=200", bus.mem_addr); end
        bus.branch_valid = 1'b1; bus.branch_target = 32'h300;
        step();
        bus.branch_valid = 1'b0; #1;
        checks++; if (bus.pc_next !== 32'h300) begin failures++; $display("FAIL breq_pc got=%0h exp=300", bus.pc_next); end
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL breq_valid got=%0h exp=0", bus.instr_valid); end
        step(); #1;
        checks++; if (bus.mem_addr !== 32'h300) begin failures++; $display("FAIL breq_addr got=%0h exp=300", bus.mem_addr); end
    endtask

    // Misaligned PC 0x302; ends parked in HOLD with decode stalled.
    task automatic test_align();
        bus.mem_rdata = 32'hE000_0300;
        step();
        pc_set = 1'b1; pc_set_val = 32'h302;
        step();
        pc_set = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL align_req got=%0h exp=0", bus.mem_req); end
        step(); #1;
        checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL align_fault got=%0h exp=1", bus.fault); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL align_fault_req got=%0h exp=0", bus.mem_req); end
        bus.branch_valid = 1'b1; bus.branch_target = 32'h40;
        step();
        bus.branch_valid = 1'b0; #1;
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL align_clear got=%0h exp=0", bus.fault); end
        checks++; if (bus.pc_next !== 32'h40) begin failures++; $display("FAIL align_pc got=%0h exp=40", bus.pc_next); end
        step(); #1;
        checks++; if (bus.mem_addr !== 32'h40) begin failures++; $display("FAIL align_resume got=%0h exp=40", bus.mem_addr); end
        bus.instr_ready = 1'b0;
        step();
`else
        checks++; if (bus.mem_addr !== 32'h302) begin failures++; $display("FAIL noalign_addr got=%0h exp=302", bus.mem_addr); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL noalign_fault got=%0h exp=0", bus.fault); end
        bus.instr_ready = 1'b0;
        step(); #1;
        checks++; if (bus.pc_next !== 32'h306) begin failures++; $display("FAIL noalign_pc got=%0h exp=306", bus.pc_next); end
`endif
    endtask

    // Reset asserted while HOLD has a valid instruction.
    task automatic test_reset_mid();
        #1;
        checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%0h exp=1", bus.instr_valid); end
        rst = 1'b1; pc_set = 1'b1; pc_set_val = 32'h0;
        step(); #1;
        checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0h exp=0", bus.instr_valid); end
        checks++; if (bus.instr_out !== 32'h0) begin failures++; $display("FAIL rmid_instr got=%0h exp=0", bus.instr_out); end
        checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL rmid_write got=%0h exp=0", bus.pc_write); end
        checks++; if (bus.pc_next !== 32'h0) begin failures++; $display("FAIL rmid_pc got=%0h exp=0", bus.pc_next); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rmid_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL rmid_fault got=%0h exp=0", bus.fault); end
        rst = 1'b0; pc_set = 1'b0; bus.instr_ready = 1'b1;
        step(); #1;
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rmid_restart_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rmid_restart_addr got=%0h exp=0", bus.mem_addr); end
    endtask

    initial begin
        bus.pc_in = 32'h0;
        bus.branch_valid = 1'b0; bus.branch_target = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        test_reset();
        test_sequential();
        test_mem_stall();
        test_decode_stall();
        test_branch_flush();
        test_wrap();
        test_branch_priority();
        test_align();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
